operand_fetch: RTL

Operand-fetch controller that drives the 8-entry × 8-bit register file as its initiator. It accepts issued instructions through a valid/ready handshake and drives the two read addresses. It captures the read data into a 2-entry operand buffer for the execute stage. It also routes writeback into the file's write port and keeps a per-register pending-write scoreboard, so no stale operand is ever delivered.

---
 rtl/operand_fetch_pkg.sv | 13 +
 rtl/operand_fetch_if.sv | 28 ++
 rtl/operand_fifo.sv | 40 ++++
 rtl/operand_fetch.sv | 75 +++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths, r0 constant and operand-buffer entry type
package operand_fetch_pkg;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NREG = 1 << AW;
    localparam logic [AW-1:0] R0 = '0;
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] rd;
        logic          wen;
    } op_entry_t;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: issue, register-file, writeback and operand buses of the fetch stage
interface operand_fetch_if;
    import operand_fetch_pkg::*;
    logic            iss_valid, iss_ready, iss_wen;
    logic [AW-1:0]   iss_rs, iss_rt, iss_rd;
    logic [AW-1:0]   rf_ra1, rf_ra2, rf_wa3;
    logic [DW-1:0]   rf_rd1, rf_rd2, rf_wd3;
    logic            rf_we3;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic            op_valid, op_ready, op_wen;
    logic [DW-1:0]   op_a, op_b;
    logic [AW-1:0]   op_rd;
    logic [NREG-1:0] busy_map;
    modport master (
        input  iss_valid, iss_rs, iss_rt, iss_rd, iss_wen, rf_rd1, rf_rd2,
        input  wb_valid, wb_addr, wb_data, op_ready,
        output iss_ready, rf_ra1, rf_ra2, rf_we3, rf_wa3, rf_wd3,
        output op_valid, op_a, op_b, op_rd, op_wen, busy_map
    );
    modport slave (
        output iss_valid, iss_rs, iss_rt, iss_rd, iss_wen, rf_rd1, rf_rd2,
        output wb_valid, wb_addr, wb_data, op_ready,
        input  iss_ready, rf_ra1, rf_ra2, rf_we3, rf_wa3, rf_wd3,
        input  op_valid, op_a, op_b, op_rd, op_wen, busy_map
    );
endinterface

// File: rtl/operand_fifo.sv
// operand_fifo: DEPTH-entry operand buffer; head entry is presented directly from storage
module operand_fifo
    import operand_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  op_entry_t                      din,
    output op_entry_t                      dout,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    op_entry_t mem [DEPTH];
    logic [PW-1:0] hd, tl;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            hd    <= '0;
            tl    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tl] <= din;
                tl      <= nxt(tl);
            end
            if (pop) hd <= nxt(hd);
            count <= count + $bits(count)'(push) - $bits(count)'(pop);
        end
    end

    assign dout = mem[hd];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: issue/operand-fetch controller with pending-write scoreboard.
// Define OPFETCH_FWD_EN to forward same-cycle writeback data into issued operands.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic            clk,
    input logic            rst_n,
    operand_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [NREG-1:0] busy, set_m, clr_m;
    logic [CW-1:0]   count;
    logic            hit_a, hit_b, busy_a, busy_b, haz_a, haz_b, waw, fire, pop;
    logic [DW-1:0]   src_a, src_b;
    op_entry_t       entry, head;

    assign bus.rf_ra1 = bus.iss_rs;
    assign bus.rf_ra2 = bus.iss_rt;
    assign bus.rf_we3 = bus.wb_valid;
    assign bus.rf_wa3 = bus.wb_addr;
    assign bus.rf_wd3 = bus.wb_data;

    assign hit_a  = bus.wb_valid && bus.wb_addr == bus.iss_rs && bus.iss_rs != R0;
    assign hit_b  = bus.wb_valid && bus.wb_addr == bus.iss_rt && bus.iss_rt != R0;
    assign busy_a = bus.iss_rs != R0 && busy[bus.iss_rs];
    assign busy_b = bus.iss_rt != R0 && busy[bus.iss_rt];
`ifdef OPFETCH_FWD_EN
    assign haz_a = busy_a && !hit_a;
    assign haz_b = busy_b && !hit_b;
    assign src_a = hit_a ? bus.wb_data : bus.rf_rd1;
    assign src_b = hit_b ? bus.wb_data : bus.rf_rd2;
`else
    // the file returns old data during its write cycle, so any same-cycle write stalls
    assign haz_a = busy_a || hit_a;
    assign haz_b = busy_b || hit_b;
    assign src_a = bus.rf_rd1;
    assign src_b = bus.rf_rd2;
`endif
    assign waw = bus.iss_wen && bus.iss_rd != R0 && busy[bus.iss_rd];

    assign bus.iss_ready = count < CW'(DEPTH) && !haz_a && !haz_b && !waw;
    assign fire  = bus.iss_valid && bus.iss_ready;
    assign entry = '{a:   bus.iss_rs == R0 ? '0 : src_a,
                     b:   bus.iss_rt == R0 ? '0 : src_b,
                     rd:  bus.iss_rd,
                     wen: bus.iss_wen};

    assign clr_m = bus.wb_valid ? NREG'(1) << bus.wb_addr : '0;
    assign set_m = (fire && bus.iss_wen && bus.iss_rd != R0) ? NREG'(1) << bus.iss_rd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= (busy & ~clr_m) | set_m;
    end

    operand_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .count (count)
    );

    assign bus.op_valid = count != '0;
    assign pop          = bus.op_valid && bus.op_ready;
    assign bus.op_a     = head.a;
    assign bus.op_b     = head.b;
    assign bus.op_rd    = head.rd;
    assign bus.op_wen   = head.wen;
    assign bus.busy_map = busy;
endmodule
